// File: rtl/vga_axil_regs_ctrl.sv
// AXI-Lite slave owning the VGA configuration register file (reg 0 = read-only ID).
// Optional byte-lane writes via `define VGA_AXIL_WSTRB_EN; otherwise wstrb is ignored.
module vga_axil_regs_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NUM_REGS = 8,
    parameter logic [DATA_W-1:0] ID_VALUE = 32'h5647_4131
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic [ADDR_W-1:0]          awaddr,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/8-1:0]        wstrb,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    input  logic [ADDR_W-1:0]          araddr,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [DATA_W-1:0]          rdata,
    output logic [1:0]                 rresp,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [NUM_REGS*DATA_W-1:0] regs_o
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // state     | meaning
    // W_COLLECT | gathering AW and W (any order), commit once both are held
    // W_RESP    | bvalid asserted, waiting for bready
    // R_IDLE    | arready high, waiting for AR
    // R_DATA    | rvalid asserted, waiting for rready
    typedef enum logic {W_COLLECT, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic                aw_got;
    logic                w_got;
    logic [IDX_W-1:0]    wr_idx;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   wr_mask;
    logic                wr_ok;
    logic                commit;
    logic [IDX_W-1:0]    rd_idx;
    logic [DATA_W-1:0]   rd_val;
    logic                rd_ok;
    logic [DATA_W-1:0]   regs_q [1:NUM_REGS-1];
    logic                unused_addr_lsb;

    assign unused_addr_lsb = ^{awaddr[1:0], araddr[1:0]};

`ifdef VGA_AXIL_WSTRB_EN
    logic [DATA_W/8-1:0] wstrb_q;

    always_comb begin
        wr_mask = '0;
        for (int k = 0; k < DATA_W/8; k++) begin
            wr_mask[k*8 +: 8] = {8{wstrb_q[k]}};
        end
    end
`else
    logic unused_wstrb;

    assign unused_wstrb = ^wstrb;
    assign wr_mask = '1;
`endif

    assign awready = !aw_got;
    assign wready  = !w_got;
    assign wr_ok   = (wr_idx != '0) && (wr_idx < IDX_W'(NUM_REGS));
    assign commit  = (w_state == W_COLLECT) && aw_got && w_got;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            w_state <= W_COLLECT;
        end else begin
            w_state <= w_next;
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_COLLECT: if (aw_got && w_got) w_next = W_RESP;
            W_RESP:    if (bready) w_next = W_COLLECT;
            default:   w_next = W_COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            wr_idx  <= '0;
            wdata_q <= '0;
`ifdef VGA_AXIL_WSTRB_EN
            wstrb_q <= '0;
`endif
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (awvalid && awready) begin
                aw_got <= 1'b1;
                wr_idx <= awaddr[ADDR_W-1:2];
            end
            if (wvalid && wready) begin
                w_got   <= 1'b1;
                wdata_q <= wdata;
`ifdef VGA_AXIL_WSTRB_EN
                wstrb_q <= wstrb;
`endif
            end
            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (wr_ok && (wr_idx == IDX_W'(i))) begin
                        regs_q[i] <= (regs_q[i] & ~wr_mask) | (wdata_q & wr_mask);
                    end
                end
            end
            // Both capture flags are released together so the next AW/W pair starts clean.
            if ((w_state == W_RESP) && bready) begin
                bvalid <= 1'b0;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
        end
    end

    assign rd_idx  = araddr[ADDR_W-1:2];
    assign rd_ok   = rd_idx < IDX_W'(NUM_REGS);
    assign arready = (r_state == R_IDLE);

    always_comb begin
        rd_val = '0;
        if (rd_idx == '0) begin
            rd_val = ID_VALUE;
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_val = regs_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (arvalid) r_next = R_DATA;
            R_DATA:  if (rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Register state is sampled before any same-edge write commit lands.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else begin
            if ((r_state == R_IDLE) && arvalid) begin
                rvalid <= 1'b1;
                rdata  <= rd_val;
                rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end else if ((r_state == R_DATA) && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    assign regs_o[0 +: DATA_W] = ID_VALUE;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule

// File: tb/tb_vga_axil_regs_ctrl.sv
// Self-checking bench for vga_axil_regs_ctrl: transaction-level register model plus per-cycle regs_o compare.
module tb_vga_axil_regs_ctrl;

    localparam int NR = 8;
    localparam logic [31:0] ID = 32'h5647_4131;

    logic              clk = 1'b0;
    logic              arst = 1'b1;
    logic [31:0]       awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [31:0]       araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [NR*32-1:0]  regs_o;

    int          vec = 0;
    int          errs = 0;
    logic [31:0] mdl [NR];
    bit          run_cmp = 1'b0;

    vga_axil_regs_ctrl dut (
        .clk(clk), .arst(arst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .regs_o(regs_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] addr);
        return int'(addr[31:2]);
    endfunction

    function automatic logic [31:0] mdl_read(input logic [31:0] addr);
        int idx = idx_of(addr);
        if (idx == 0) return ID;
        if (idx < NR) return mdl[idx];
        return 32'h0;
    endfunction

    function automatic bit wr_ok(input logic [31:0] addr);
        int idx = idx_of(addr);
        return (idx != 0) && (idx < NR);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] res = old;
`ifdef VGA_AXIL_WSTRB_EN
        for (int k = 0; k < 4; k++) if (strb[k]) res[k*8 +: 8] = data[k*8 +: 8];
`else
        res = data;
        if (strb === 4'hx) res = old;
`endif
        return res;
    endfunction

    always @(negedge clk) begin
        if (run_cmp && !arst) begin
            for (int i = 0; i < NR; i++) begin
                chk($sformatf("regs_o[%0d]", i), regs_o[i*32 +: 32], (i == 0) ? ID : mdl[i]);
            end
        end
    end

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, input bit abort,
                            output logic [1:0] resp);
        logic [1:0] exp_resp;
        int n_aw, n_w;
        exp_resp = wr_ok(addr) ? 2'b00 : 2'b10;
        fork
            begin
                repeat (aw_dly + 1) @(posedge clk);
                #1 awaddr = addr; awvalid = 1'b1;
                n_aw = 0;
                do begin @(negedge clk); n_aw++; end while (!awready && n_aw < 50);
                if (!awready) chk("aw_timeout", 32'd0, 32'd1);
                @(posedge clk);
                #1 awvalid = 1'b0;
            end
            begin
                repeat (w_dly + 1) @(posedge clk);
                #1 wdata = data; wstrb = strb; wvalid = 1'b1;
                n_w = 0;
                do begin @(negedge clk); n_w++; end while (!wready && n_w < 50);
                if (!wready) chk("w_timeout", 32'd0, 32'd1);
                @(posedge clk);
                #1 wvalid = 1'b0;
            end
        join
        @(negedge clk);
        chk("bvalid_before_commit", bvalid, 1'b0);
        chk("awready_held_low", awready, 1'b0);
        chk("wready_held_low", wready, 1'b0);
        @(posedge clk);
        if (wr_ok(addr)) mdl[idx_of(addr)] = merge(mdl[idx_of(addr)], data, strb);
        @(negedge clk);
        chk("bvalid_after_commit", bvalid, 1'b1);
        chk("bresp", bresp, exp_resp);
        resp = bresp;
        repeat (b_dly) begin
            @(posedge clk);
            @(negedge clk);
            chk("bvalid_hold", bvalid, 1'b1);
            chk("bresp_hold", bresp, exp_resp);
        end
        if (abort) begin
            arst = 1'b1;
            #1;
            chk("bvalid_on_arst", bvalid, 1'b0);
            chk("awready_on_arst", awready, 1'b1);
            chk("wready_on_arst", wready, 1'b1);
            chk("reg3_on_arst", regs_o[3*32 +: 32], 32'h0);
            chk("reg4_on_arst", regs_o[4*32 +: 32], 32'h0);
            for (int i = 0; i < NR; i++) mdl[i] = 32'h0;
            @(negedge clk);
            @(negedge clk);
            arst = 1'b0;
        end else begin
            bready = 1'b1;
            @(posedge clk);
            #1 bready = 1'b0;
            @(negedge clk);
            chk("bvalid_after_b", bvalid, 1'b0);
            chk("awready_after_b", awready, 1'b1);
            chk("wready_after_b", wready, 1'b1);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        int n;
        repeat (ar_dly + 1) @(posedge clk);
        #1 araddr = addr; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 50);
        if (!arready) chk("ar_timeout", 32'd0, 32'd1);
        exp_d = mdl_read(addr);
        exp_r = (idx_of(addr) < NR) ? 2'b00 : 2'b10;
        @(posedge clk);
        #1 arvalid = 1'b0;
        @(negedge clk);
        chk("rvalid", rvalid, 1'b1);
        chk("rdata", rdata, exp_d);
        chk("rresp", rresp, exp_r);
        chk("arready_busy", arready, 1'b0);
        data = rdata;
        resp = rresp;
        repeat (r_dly) begin
            @(posedge clk);
            @(negedge clk);
            chk("rvalid_hold", rvalid, 1'b1);
            chk("rdata_hold", rdata, exp_d);
        end
        rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
        @(negedge clk);
        chk("rvalid_after_r", rvalid, 1'b0);
        chk("arready_after_r", arready, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, errs=%0d", errs);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r, rr;
        logic [31:0] a;
        for (int i = 0; i < NR; i++) mdl[i] = 32'h0;
        arst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_awready", awready, 1'b1);
        chk("rst_wready", wready, 1'b1);
        chk("rst_arready", arready, 1'b1);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_rresp", rresp, 2'b00);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_reg0", regs_o[31:0], 32'h5647_4131);
        arst = 1'b0;
        run_cmp = 1'b1;

        do_read(32'h0, 0, 0, d, r);
        chk("id_read", d, 32'h5647_4131);
        chk("id_resp", r, 2'b00);
        do_read(32'h4, 0, 1, d, r);
        chk("reg1_reset_read", d, 32'h0);
        chk("reg1_reset_resp", r, 2'b00);

        do_write(32'h8, 32'h0000_0280, 4'hF, 0, 2, 4, 1'b0, r);
        chk("wr_0x8_resp", r, 2'b00);
        chk("regs_o2_lit", regs_o[2*32 +: 32], 32'h0000_0280);
        do_read(32'h8, 0, 0, d, r);
        chk("rd_0x8_lit", d, 32'h0000_0280);

        do_write(32'h0, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 1'b0, r);
        chk("wr_0x0_slverr", r, 2'b10);
        do_write(32'h20, 32'hDEAD_BEEF, 4'hF, 1, 0, 0, 1'b0, r);
        chk("wr_0x20_slverr", r, 2'b10);
        do_read(32'h20, 0, 0, d, r);
        chk("rd_0x20_data", d, 32'h0);
        chk("rd_0x20_slverr", r, 2'b10);

        do_write(32'hC, 32'h5, 4'hF, 0, 0, 0, 1'b0, r);
        fork
            do_write(32'hC, 32'h1111_1111, 4'hF, 0, 0, 0, 1'b0, r);
            do_read(32'hC, 1, 0, d, rr);
        join
        chk("same_edge_old_value", d, 32'h5);
        do_read(32'hC, 0, 0, d, r);
        chk("same_edge_new_value", d, 32'h1111_1111);

`ifdef VGA_AXIL_WSTRB_EN
        do_write(32'hC, 32'hAABB_CCDD, 4'b0101, 0, 0, 0, 1'b0, r);
        chk("wstrb_merge", regs_o[3*32 +: 32], 32'h11BB_11DD);
        do_write(32'hC, 32'h0, 4'b0000, 0, 0, 0, 1'b0, r);
        chk("wstrb_zero_resp", r, 2'b00);
        chk("wstrb_zero_keep", regs_o[3*32 +: 32], 32'h11BB_11DD);
`endif

        do_write(32'h10, 32'hCAFE_0001, 4'hF, 0, 0, 2, 1'b1, r);
        do_write(32'h10, 32'h0000_0077, 4'hF, 0, 1, 0, 1'b0, r);
        chk("post_rst_write_resp", r, 2'b00);
        chk("post_rst_reg4", regs_o[4*32 +: 32], 32'h0000_0077);
        chk("post_rst_reg3", regs_o[3*32 +: 32], 32'h0);

        for (int t = 0; t < 80; t++) begin
            int op;
            logic [31:0] wd;
            logic [3:0]  ws;
            op = int'($urandom_range(0, 2));
            a  = ($urandom_range(0, 10) << 2) | $urandom_range(0, 3);
            wd = $urandom;
            ws = 4'($urandom_range(0, 15));
            case (op)
                0: do_write(a, wd, ws, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                            int'($urandom_range(0, 3)), 1'b0, r);
                1: do_read(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), d, r);
                default: fork
                    do_write(a, wd, ws, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                             int'($urandom_range(0, 2)), 1'b0, r);
                    do_read(($urandom_range(0, 1) != 0) ? a : ($urandom_range(0, 9) << 2),
                            int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), d, rr);
                join
            endcase
        end

        repeat (2) @(negedge clk);
        run_cmp = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
